// File: rtl/xor_gate_behav_core_if.sv
// Operand/result bundle for the XOR block: the master drives a/b, the slave returns
// the combinational result plus its registered copy, parity and hit count.
interface xor_gate_behav_core_if #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             par_q;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output a,
        output b,
        input  y,
        input  y_q,
        input  par_q,
        input  hit_cnt
    );

    modport slave (
        input  a,
        input  b,
        output y,
        output y_q,
        output par_q,
        output hit_cnt
    );
endinterface

// File: rtl/xor_gate_behav_core.sv
// Bitwise XOR with a combinational output, plus a registered copy, its odd parity
// and a saturating count of cycles where the result was non-zero.
module xor_gate_behav_core #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    xor_gate_behav_core_if.slave  bus
);
    logic [WIDTH-1:0] xor_w;
    logic [WIDTH-1:0] res_q, res_d;
    logic             parity_q, parity_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hit_w;
    logic             sat_w;

    // Per-bit XOR so an X/Z on one operand bit only poisons that result bit.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_xor
            assign xor_w[gi] = bus.a[gi] ^ bus.b[gi];
        end
    endgenerate

    assign bus.y = xor_w;
    assign hit_w = |xor_w;
    assign sat_w = &cnt_q;

    always_comb begin
        res_d    = xor_w;
        parity_d = ^xor_w;
        cnt_d    = cnt_q;
        if (hit_w && !sat_w) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            res_q    <= '0;
            parity_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            res_q    <= res_d;
            parity_q <= parity_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.y_q     = res_q;
    assign bus.par_q   = parity_q;
    assign bus.hit_cnt = cnt_q;
endmodule

// File: tb/tb_xor_gate_behav_core.sv
// Directed checks of the XOR block: truth table, reset, latency, saturation, wide operands.
`timescale 1ns/100ps
module tb_xor_gate_behav_core;
    logic clk;
    logic clk_en;
    logic rst1, rst_s, rst4;
    int   n_assert;
    int   n_fail;

    xor_gate_behav_core_if #(.WIDTH(1), .CNT_W(8)) if1 ();
    xor_gate_behav_core_if #(.WIDTH(1), .CNT_W(2)) if_s ();
    xor_gate_behav_core_if #(.WIDTH(4), .CNT_W(8)) if4 ();

    xor_gate_behav_core #(.WIDTH(1), .CNT_W(8)) dut1 (.clk(clk), .rst(rst1), .bus(if1));
    xor_gate_behav_core #(.WIDTH(1), .CNT_W(2)) dut_s (.clk(clk), .rst(rst_s), .bus(if_s));
    xor_gate_behav_core #(.WIDTH(4), .CNT_W(8)) dut4 (.clk(clk), .rst(rst4), .bus(if4));

    initial clk = 1'b0;
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_sat [5] = '{1, 2, 3, 3, 3};
        n_assert = 0;
        n_fail   = 0;
        clk_en   = 1'b0;
        rst1 = 1'b1; rst_s = 1'b1; rst4 = 1'b1;
        if_s.a = 1'b0; if_s.b = 1'b0;
        if4.a  = 4'h0; if4.b  = 4'h0;

        // Combinational truth table with the clock stopped
        if1.a = 1'b0; if1.b = 1'b0; #1; chk("tt_00", 32'(if1.y), 32'd0); #9;
        if1.a = 1'b0; if1.b = 1'b1; #1; chk("tt_01", 32'(if1.y), 32'd1); #9;
        if1.a = 1'b1; if1.b = 1'b0; #1; chk("tt_10", 32'(if1.y), 32'd1); #9;
        if1.a = 1'b1; if1.b = 1'b1; #1; chk("tt_11", 32'(if1.y), 32'd0); #9;
        if1.a = 1'bx; if1.b = 1'b0; #1; chk("tt_x0", {31'd0, if1.y}, {31'd0, 1'bx}); #9;

        // Reset held for two edges
        if1.a = 1'b1; if1.b = 1'b0;
        clk_en = 1'b1;
        tick(); tick();
        chk("rst_y",    32'(if1.y),       32'd1);
        chk("rst_y_q",  32'(if1.y_q),     32'd0);
        chk("rst_par",  32'(if1.par_q),   32'd0);
        chk("rst_cnt",  32'(if1.hit_cnt), 32'd0);
        rst1 = 1'b0;
        tick();
        chk("rel_y_q",  32'(if1.y_q),     32'd1);
        chk("rel_par",  32'(if1.par_q),   32'd1);
        chk("rel_cnt",  32'(if1.hit_cnt), 32'd1);

        // Registered latency from a fresh count
        rst1 = 1'b1; tick(); rst1 = 1'b0;
        if1.a = 1'b0; if1.b = 1'b1; #1;
        chk("lat0_y", 32'(if1.y), 32'd1);
        tick();
        chk("lat0_y_q", 32'(if1.y_q), 32'd1);
        chk("lat0_cnt", 32'(if1.hit_cnt), 32'd1);
        if1.a = 1'b1; if1.b = 1'b1; #1;
        chk("lat1_y", 32'(if1.y), 32'd0);
        chk("lat1_y_q_hold", 32'(if1.y_q), 32'd1);
        tick();
        chk("lat1_y_q", 32'(if1.y_q), 32'd0);
        chk("lat1_par", 32'(if1.par_q), 32'd0);
        chk("lat1_cnt", 32'(if1.hit_cnt), 32'd1);
        if1.a = 1'b1; if1.b = 1'b0;
        tick();
        chk("lat2_y_q", 32'(if1.y_q), 32'd1);
        chk("lat2_cnt", 32'(if1.hit_cnt), 32'd2);

        // Reset wins over an increment on the same edge
        rst1 = 1'b1;
        tick();
        chk("mid_rst_cnt", 32'(if1.hit_cnt), 32'd0);
        chk("mid_rst_y_q", 32'(if1.y_q), 32'd0);
        rst1 = 1'b0;

        // Saturation with a 2-bit counter
        if_s.a = 1'b1; if_s.b = 1'b0; rst_s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("sat_cnt_%0d", i), 32'(if_s.hit_cnt), 32'(exp_sat[i]));
        end
        rst_s = 1'b1;
        tick();
        chk("sat_rst_cnt", 32'(if_s.hit_cnt), 32'd0);

        // Wide operand
        rst4 = 1'b0;
        if4.a = 4'b1010; if4.b = 4'b0110; #1;
        chk("w4_y0", 32'(if4.y), 32'hC);
        tick();
        chk("w4_y_q0", 32'(if4.y_q), 32'hC);
        chk("w4_par0", 32'(if4.par_q), 32'd0);
        if4.a = 4'b1111; if4.b = 4'b0001; #1;
        chk("w4_y1", 32'(if4.y), 32'hE);
        tick();
        chk("w4_y_q1", 32'(if4.y_q), 32'hE);
        chk("w4_par1", 32'(if4.par_q), 32'd1);
        chk("w4_cnt", 32'(if4.hit_cnt), 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
